// File: rtl/reward_effect_manager.sv
// reward_effect_manager: reward pickup detection and per-type effect timers for the tank game
//
// Build option: define REWARD_STACK_EN so that re-granting an active effect adds
// DURATION to its timer, saturating at MAX_DURATION. By default a re-grant reloads DURATION.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   i_tick             one-clk timer strobe (4 Hz)
//   i_enable           reward subsystem enable; low clears every effect
//   i_mode_infinity    1 = infinity mode (type 1 adds game time instead of a timed effect)
//   i_pickup_valid     reward generator has a reward placed
//   i_reward_type      placed reward type, 1..NUM_TYPES
//   i_reward_xpos/ypos reward tile; 0 on either axis means no reward
//   i_tank_xpos/ypos   player tank tile
//   o_pickup_ack       one-cycle pickup acknowledge
//   o_effect_active    bit i-1 high while type i is active
//   o_addtime_pulse    one-cycle add-game-time strobe
//   o_last_type        most recently granted type, 0 = none
//   o_last_remain      remaining ticks of o_last_type's timer
module reward_effect_manager #(
    parameter int NUM_TYPES    = 4,
    parameter int TYPE_W       = 3,
    parameter int GRID_W       = 5,
    parameter int CNT_W        = 10,
    parameter int DURATION     = 20,
    parameter int MAX_DURATION = 60
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_tick,
    input  logic                 i_enable,
    input  logic                 i_mode_infinity,
    input  logic                 i_pickup_valid,
    input  logic [TYPE_W-1:0]    i_reward_type,
    input  logic [GRID_W-1:0]    i_reward_xpos,
    input  logic [GRID_W-1:0]    i_reward_ypos,
    input  logic [GRID_W-1:0]    i_tank_xpos,
    input  logic [GRID_W-1:0]    i_tank_ypos,
    output logic                 o_pickup_ack,
    output logic [NUM_TYPES-1:0] o_effect_active,
    output logic                 o_addtime_pulse,
    output logic [TYPE_W-1:0]    o_last_type,
    output logic [CNT_W-1:0]     o_last_remain
);

    localparam logic [CNT_W-1:0] L_DUR = CNT_W'(DURATION);

    if ((1 << TYPE_W) <= NUM_TYPES || MAX_DURATION < DURATION) begin : g_cfg_err
        $error("reward_effect_manager: invalid parameter combination");
    end

    logic [CNT_W-1:0]     r_timer [NUM_TYPES];
    logic [CNT_W-1:0]     w_timer_nxt [NUM_TYPES];
    logic [CNT_W-1:0]     w_load [NUM_TYPES];
    logic [NUM_TYPES-1:0] w_grant;
    logic [NUM_TYPES-1:0] w_active_nxt;
    logic [NUM_TYPES-1:0] r_active;
    logic                 r_armed;
    logic                 r_ack;
    logic                 r_addtime;
    logic [TYPE_W-1:0]    r_last_type;
    logic [TYPE_W-1:0]    w_last_type_nxt;
    logic [CNT_W-1:0]     w_remain;
    logic                 w_match;
    logic                 w_addtime;
    logic                 w_armed_nxt;

    assign w_match = i_enable && i_pickup_valid && r_armed
                  && (i_reward_xpos != '0) && (i_reward_ypos != '0)
                  && (i_reward_xpos == i_tank_xpos) && (i_reward_ypos == i_tank_ypos)
                  && (i_reward_type != '0) && (i_reward_type <= TYPE_W'(NUM_TYPES));

    // In infinity mode type 1 is converted into extra game time, not a timed effect
    assign w_addtime = w_match && i_mode_infinity && (i_reward_type == TYPE_W'(1));

    // Re-arm as soon as the generator withdraws the reward, so a held valid acks only once
    assign w_armed_nxt = !i_enable || !i_pickup_valid || (r_armed && !w_match);

    assign w_last_type_nxt = !i_enable ? '0 : (w_match && !w_addtime) ? i_reward_type : r_last_type;

`ifdef REWARD_STACK_EN
    localparam logic [CNT_W:0] L_MAX = (CNT_W+1)'(MAX_DURATION);
    logic [CNT_W:0] w_sum [NUM_TYPES];
    always_comb begin
        for (int i = 0; i < NUM_TYPES; i++) begin
            w_sum[i] = {1'b0, r_timer[i]} + {1'b0, L_DUR};
            w_load[i] = (r_timer[i] == '0) ? L_DUR : (w_sum[i] > L_MAX) ? L_MAX[CNT_W-1:0] : w_sum[i][CNT_W-1:0];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_TYPES; i++) begin
            w_load[i] = L_DUR;
        end
    end
`endif

    // A grant takes priority over a same-cycle tick on that timer
    always_comb begin
        for (int i = 0; i < NUM_TYPES; i++) begin
            w_grant[i] = w_match && !w_addtime && (i_reward_type == TYPE_W'(i + 1));
            w_timer_nxt[i] = !i_enable ? '0
                           : w_grant[i] ? w_load[i]
                           : (i_tick && r_timer[i] != '0) ? r_timer[i] - 1'b1
                           : r_timer[i];
            w_active_nxt[i] = (w_timer_nxt[i] != '0);
        end
    end

    always_comb begin
        w_remain = '0;
        for (int i = 0; i < NUM_TYPES; i++) begin
            if (r_last_type == TYPE_W'(i + 1)) w_remain = r_timer[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_TYPES; i++) r_timer[i] <= '0;
            r_active    <= '0;
            r_armed     <= 1'b1;
            r_ack       <= 1'b0;
            r_addtime   <= 1'b0;
            r_last_type <= '0;
        end else begin
            for (int i = 0; i < NUM_TYPES; i++) r_timer[i] <= w_timer_nxt[i];
            r_active    <= w_active_nxt;
            r_armed     <= w_armed_nxt;
            r_ack       <= w_match;
            r_addtime   <= w_addtime;
            r_last_type <= w_last_type_nxt;
        end
    end

    assign o_pickup_ack    = r_ack;
    assign o_effect_active = r_active;
    assign o_addtime_pulse = r_addtime;
    assign o_last_type     = r_last_type;
    assign o_last_remain   = w_remain;

endmodule

// File: tb/tb_reward_effect_manager.sv
// tb_reward_effect_manager: directed vector table plus multi-cycle sequences for reward_effect_manager
module tb_reward_effect_manager;

    logic       clk = 1'b0;
    logic       rst, tick, enable, mode_inf, valid;
    logic [2:0] rtype;
    logic [4:0] rx, ry, tx, ty;
    logic       ack, addtime;
    logic [3:0] active;
    logic [2:0] last_type;
    logic [9:0] last_remain;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reward_effect_manager dut (
        .clk(clk), .rst(rst), .i_tick(tick), .i_enable(enable), .i_mode_infinity(mode_inf),
        .i_pickup_valid(valid), .i_reward_type(rtype),
        .i_reward_xpos(rx), .i_reward_ypos(ry), .i_tank_xpos(tx), .i_tank_ypos(ty),
        .o_pickup_ack(ack), .o_effect_active(active), .o_addtime_pulse(addtime),
        .o_last_type(last_type), .o_last_remain(last_remain)
    );

    typedef struct {
        logic       rst, en, mode, valid;
        logic [2:0] typ;
        logic [4:0] rx, ry, tx, ty;
        logic       tick;
        logic       e_ack;
        logic [3:0] e_act;
        logic       e_add;
        logic [2:0] e_lt;
        logic [9:0] e_lr;
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic m, input logic v, input logic [2:0] t,
                         input logic [4:0] a, input logic [4:0] b, input logic [4:0] c, input logic [4:0] d,
                         input logic k);
        rst = r; enable = e; mode_inf = m; valid = v; rtype = t;
        rx = a; ry = b; tx = c; ty = d; tick = k;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic e_ack, input logic [3:0] e_act, input logic e_add,
                           input logic [2:0] e_lt, input logic [9:0] e_lr);
        chk({tag, ".ack"}, int'(ack), int'(e_ack));
        chk({tag, ".active"}, int'(active), int'(e_act));
        chk({tag, ".addtime"}, int'(addtime), int'(e_add));
        chk({tag, ".last_type"}, int'(last_type), int'(e_lt));
        chk({tag, ".last_remain"}, int'(last_remain), int'(e_lr));
    endtask

    task automatic grant(input logic [2:0] t);
        drive(0, 1, 0, 1, t, 3, 4, 3, 4, 0);
        drive(0, 1, 0, 0, t, 3, 4, 3, 4, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) drive(0, 1, 0, 0, 0, 3, 4, 3, 4, 1);
    endtask

    int acks;
    int refresh_exp;

    initial begin
        //         rst en md vl ty rx ry tx ty tk | ack act add lt lr
        vt[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 4'h0, 0, 0, 0};
        vt[1]  = '{0, 1, 0, 1, 2, 3, 4, 3, 4, 0,   1, 4'h2, 0, 2, 20};
        vt[2]  = '{0, 1, 0, 1, 2, 3, 4, 3, 4, 0,   0, 4'h2, 0, 2, 20};
        vt[3]  = '{0, 1, 0, 0, 2, 3, 4, 3, 4, 1,   0, 4'h2, 0, 2, 19};
        vt[4]  = '{0, 1, 0, 1, 2, 0, 4, 0, 4, 0,   0, 4'h2, 0, 2, 19};
        vt[5]  = '{0, 1, 0, 1, 0, 3, 4, 3, 4, 0,   0, 4'h2, 0, 2, 19};
        vt[6]  = '{0, 1, 0, 1, 5, 3, 4, 3, 4, 0,   0, 4'h2, 0, 2, 19};
        vt[7]  = '{0, 1, 0, 1, 3, 3, 4, 3, 5, 0,   0, 4'h2, 0, 2, 19};
        vt[8]  = '{0, 1, 1, 1, 1, 3, 4, 3, 4, 0,   1, 4'h2, 1, 2, 19};
        vt[9]  = '{0, 1, 1, 0, 1, 3, 4, 3, 4, 0,   0, 4'h2, 0, 2, 19};
        vt[10] = '{0, 1, 0, 1, 1, 3, 4, 3, 4, 0,   1, 4'h3, 0, 1, 20};
        vt[11] = '{0, 1, 0, 0, 1, 3, 4, 3, 4, 1,   0, 4'h3, 0, 1, 19};
        vt[12] = '{0, 0, 0, 1, 2, 3, 4, 3, 4, 1,   0, 4'h0, 0, 0, 0};
        vt[13] = '{0, 0, 0, 0, 2, 3, 4, 3, 4, 1,   0, 4'h0, 0, 0, 0};
        vt[14] = '{0, 1, 0, 1, 4, 3, 4, 3, 4, 0,   1, 4'h8, 0, 4, 20};
        vt[15] = '{0, 1, 0, 0, 4, 3, 4, 3, 4, 0,   0, 4'h8, 0, 4, 20};

        for (int i = 0; i < 16; i++) begin
            drive(vt[i].rst, vt[i].en, vt[i].mode, vt[i].valid, vt[i].typ,
                  vt[i].rx, vt[i].ry, vt[i].tx, vt[i].ty, vt[i].tick);
            chk_all($sformatf("vec%0d", i), vt[i].e_ack, vt[i].e_act, vt[i].e_add, vt[i].e_lt, vt[i].e_lr);
        end

        // Expiry: effect lasts exactly DURATION ticks
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        grant(2);
        ticks(19);
        chk_all("expiry19", 0, 4'h2, 0, 2, 1);
        ticks(1);
        chk_all("expiry20", 0, 4'h0, 0, 2, 0);
        ticks(1);
        chk("expiry_nowrap", int'(last_remain), 0);

        // Held valid: one ack over 10 cycles, second ack after a 1-cycle drop
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 0, 1, 3, 3, 4, 3, 4, 0);
            acks += int'(ack);
        end
        chk("held_valid_acks", acks, 1);
        drive(0, 1, 0, 0, 3, 3, 4, 3, 4, 0);
        drive(0, 1, 0, 1, 3, 3, 4, 3, 4, 0);
        chk("reassert_ack", int'(ack), 1);

        // Concurrent: type 3 then, 5 ticks later, type 4
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        grant(3);
        ticks(5);
        grant(4);
        chk("conc_both", int'(active), 4'hC);
        ticks(15);
        chk_all("conc_t20", 0, 4'h8, 0, 4, 5);
        ticks(5);
        chk_all("conc_t25", 0, 4'h0, 0, 4, 0);

        // Re-grant colliding with a tick at remain = 7
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        grant(2);
        ticks(13);
        chk("collide_pre", int'(last_remain), 7);
`ifdef REWARD_STACK_EN
        refresh_exp = 27;
`else
        refresh_exp = 20;
`endif
        drive(0, 1, 0, 1, 2, 3, 4, 3, 4, 1);
        chk("collide_grant", int'(last_remain), refresh_exp);
        chk("collide_ack", int'(ack), 1);

        // Reset mid-effect with two effects running
        drive(0, 1, 0, 0, 2, 3, 4, 3, 4, 0);
        grant(1);
        chk("pre_rst_active", int'(active), 4'h3);
        drive(1, 1, 0, 1, 2, 3, 4, 3, 4, 1);
        chk_all("rst_mid", 0, 4'h0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reward_effect_manager.md
Name: reward_effect_manager

Overview:
- Parametrised successor of the tank-game reward logic.
- Detects when the player tank reaches the active reward tile and acknowledges the pickup to the reward generator.
- Runs one independent duration timer per reward type, so concurrent effects never share a counter.
- Drives per-effect active flags to the game logic, and remaining-time data for the most recently granted effect to the information display.

Parameters:
- NUM_TYPES, 4, number of timed reward types; type codes 1..NUM_TYPES.
- TYPE_W, 3, width of reward_type; must satisfy 2^TYPE_W > NUM_TYPES.
- GRID_W, 5, width of tile x/y coordinates.
- CNT_W, 10, width of each effect timer.
- DURATION, 20, effect length in ticks; 1..2^CNT_W-1.
- MAX_DURATION, 60, saturation ceiling used only with REWARD_STACK_EN; DURATION..2^CNT_W-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- tick  in  1  one-clk-wide strobe at 4 Hz; the timer time base.
- enable  in  1  reward subsystem enable.
- mode_infinity  in  1  1 = infinity game mode, 0 = classic.
- pickup_valid  in  1  reward generator has a reward placed (set_require).
- reward_type  in  TYPE_W  type of the placed reward.
- reward_xpos, reward_ypos  in  GRID_W each  reward tile position.
- tank_xpos, tank_ypos  in  GRID_W each  player tank tile position.
- pickup_ack  out  1  one-cycle pickup acknowledge (set_finish).
- effect_active  out  NUM_TYPES  bit i-1 high while type i is active.
- addtime_pulse  out  1  one-cycle strobe: add game time (infinity mode, type 1).
- last_type  out  TYPE_W  type most recently granted; 0 = none.
- last_remain  out  CNT_W  remaining ticks of last_type's timer.

Behaviour:
- Reset (rst=1 at a clk edge):
  - all timers = 0, effect_active = 0, pickup_ack = 0, addtime_pulse = 0, last_type = 0, last_remain = 0.
  - armed flag = 1.
  - Reset mid-effect aborts all effects immediately.
- Match condition, evaluated every clk:
  - enable & pickup_valid & armed;
  - reward_xpos != 0 and reward_ypos != 0 (0 means "no reward");
  - reward_xpos == tank_xpos and reward_ypos == tank_ypos;
  - 1 <= reward_type <= NUM_TYPES.
  - An out-of-range type never matches and is never acked.
- On match, registered, 1-cycle latency:
  - pickup_ack pulses high for exactly one clk.
  - armed clears; it re-arms on the first clk with pickup_valid = 0. This gives one ack per placement, even if the generator holds pickup_valid.
- Grant on match:
  - If mode_infinity = 1 and reward_type = 1: addtime_pulse pulses with pickup_ack; no timer is loaded; last_type is unchanged.
  - Otherwise: timer[type] loads DURATION (refresh, not extend, when already active); last_type = type.
- Timers:
  - On tick, every nonzero timer decrements by 1.
  - A timer at 0 stays 0; no wrap.
  - effect_active[i] = (timer[i+1] != 0), registered with the timer.
  - An effect lasts exactly DURATION ticks after grant.
- Simultaneous grant and tick on the same type: the grant wins; the timer holds DURATION and does not decrement that cycle. Other types still decrement.
- last_remain = timer[last_type], or 0 when last_type = 0.
  - When that timer reaches 0, last_type stays set and last_remain reads 0.
- enable = 0:
  - no matches;
  - all timers clear to 0 on the next clk;
  - last_type clears to 0;
  - armed is forced to 1.
- Gating:
  - tick with enable = 0 has no effect.
  - tick width greater than 1 clk is a caller error; each high cycle counts as a tick.

Optional Feature:
- Macro: REWARD_STACK_EN.
- Defined: a grant on an already-active type adds DURATION to the current timer, saturating at MAX_DURATION. A grant on an idle type loads DURATION.
- Undefined: a grant always reloads DURATION (refresh). MAX_DURATION is unused.

Test Plan:
- Pickup and expiry: reset; enable=1, pickup_valid=1, type=2, reward=(3,4), tank=(3,4) → pickup_ack high exactly 1 clk after match; effect_active=4'b0010; last_remain=20; after 20 ticks effect_active=0, last_remain=0.
- Held valid and zero position: pickup_valid held high 10 clks on a match → exactly one ack. Drop for 1 clk, reassert → second ack. Reward at (0,4) with tank at (0,4) → no ack.
- Concurrent effects: grant type 3, 5 ticks later grant type 4 → both bits set. Type 3 clears at tick 20, type 4 at tick 25; counters are independent.
- Mode split: mode_infinity=1, type 1 → addtime_pulse 1 clk, effect_active[0]=0. mode_infinity=0, type 1 → effect_active[0]=1. Type 0 or type 5 → no ack.
- Refresh and collision: type 2 active at remain=7; re-grant in the same clk as tick → remain=20 without REWARD_STACK_EN. With the macro defined → 27. At remain=50, re-grant → 60 (saturated).
- Disable/reset mid-effect: two effects active; enable=0 for 1 clk → all timers 0, last_type=0. Repeat with rst=1 → all outputs at reset values on the next edge.
